// File: rtl/rs_pkg.sv
// rs_pkg: shared Reed-Solomon field defaults, FSM states and elaboration-time alpha powers
package rs_pkg;
  localparam int M = 8;
  localparam int N = 204;
  localparam int NSYM = 16;
  localparam int PRIM_POLY = 'h11D;
  typedef enum logic {IDLE, ACC} state_t;
  function automatic int gf_alpha_pow(int k, int m, int poly);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) begin
      r = r << 1;
      if (((r >> m) & 1) != 0) r = r ^ poly;
    end
    return r;
  endfunction
endpackage

// File: rtl/rs_gf_const_mul.sv
// rs_gf_const_mul: GF(2^M) multiply of x by the constant alpha^K as a pure XOR network
module rs_gf_const_mul #(
  parameter int M = rs_pkg::M,
  parameter int PRIM_POLY = rs_pkg::PRIM_POLY,
  parameter int K = 0
) (
  input  logic [M-1:0] x,
  output logic [M-1:0] y
);
  import rs_pkg::*;
  function automatic logic [M*M-1:0] cols_f();
    logic [M*M-1:0] c;
    for (int i = 0; i < M; i++) c[i*M +: M] = M'(gf_alpha_pow(K + i, M, PRIM_POLY));
    return c;
  endfunction
  localparam logic [M*M-1:0] COLS = cols_f();
  always_comb begin
    y = '0;
    for (int i = 0; i < M; i++) y = y ^ (COLS[i*M +: M] & {M{x[i]}});
  end
endmodule

// File: rtl/rs_syndrome_engine.sv
// rs_syndrome_engine: streaming Horner syndrome accumulator with frame sync and registered outputs
module rs_syndrome_engine #(
  parameter int M = rs_pkg::M,
  parameter int N = rs_pkg::N,
  parameter int NSYM = rs_pkg::NSYM,
  parameter int PRIM_POLY = rs_pkg::PRIM_POLY,
  parameter int FCR = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [M-1:0]      In_Sym,
  input  logic              In_Valid,
  input  logic              In_Sof,
  output logic [NSYM*M-1:0] Out_S,
  output logic              Out_Valid,
  output logic              Out_NoErr,
  output logic              Sync_Err
);
  import rs_pkg::*;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NSYM*M-1:0] s_q, s_d, mul, out_s_q, out_s_d;
  logic out_valid_q, out_valid_d, no_err_q, no_err_d, sync_err_q, sync_err_d;
  logic sof, accept, restart, last;
  for (genvar g = 0; g < NSYM; g++) begin : g_mul
    rs_gf_const_mul #(.M(M), .PRIM_POLY(PRIM_POLY), .K(FCR + g)) u_mul (
      .x(s_q[g*M +: M]),
      .y(mul[g*M +: M])
    );
  end
  always_comb begin
    sof = In_Valid & In_Sof;
    accept = In_Valid & (sof | state_q == ACC);
    restart = sof & state_q == ACC & cnt_q != '0;
    last = accept & ((sof ? CW'(0) : cnt_q) == CW'(N - 1));
    s_d = accept ? (sof ? {NSYM{In_Sym}} : mul ^ {NSYM{In_Sym}}) : s_q;
    cnt_d = last ? '0 : sof ? CW'(1) : accept ? cnt_q + CW'(1) : cnt_q;
    state_d = last ? IDLE : sof ? ACC : state_q;
    out_s_d = last ? s_d : out_s_q;
    no_err_d = last ? ~|s_d : no_err_q;
    out_valid_d = last;
    sync_err_d = restart;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      s_q <= '0;
      out_s_q <= '0;
      no_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      out_s_q <= out_s_d;
      no_err_q <= no_err_d;
      out_valid_q <= out_valid_d;
      sync_err_q <= sync_err_d;
    end
  end
  assign Out_S = out_s_q;
  assign Out_Valid = out_valid_q;
  assign Out_NoErr = no_err_q;
  assign Sync_Err = sync_err_q;
endmodule

// File: doc/rs_syndrome_engine.md
RS_SYNDROME_ENGINE -- requirements
Module: rs_syndrome_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  M          8      symbol width, bits (GF(2^M))
  N          204    codeword length, symbols
  NSYM       16     syndromes per codeword (2t)
  PRIM_POLY  9'h11D field generator x^8+x^4+x^3+x^2+1
  FCR        0      first consecutive root exponent; roots alpha^(FCR+j), j=0..NSYM-1
REQ-002 Ports, one per line: name  direction  width  meaning.
  Clk        in   1        single clock, rising edge
  Reset      in   1        synchronous, active-high
  In_Sym     in   M        received symbol, highest-degree coefficient first
  In_Valid   in   1        In_Sym valid this cycle
  In_Sof     in   1        qualified by In_Valid; marks first symbol of a codeword
  Out_S      out  NSYM*M   syndromes; S_j at bits [j*M +: M], j=0 is S_1
  Out_Valid  out  1        one-cycle strobe: Out_S/Out_NoErr updated
  Out_NoErr  out  1        all NSYM syndromes zero
  Sync_Err   out  1        one-cycle strobe: In_Sof seen mid-codeword
REQ-003 Clk is the only clock; Reset is synchronous and active-high.

Function
REQ-004 Accumulate per root via Horner: S_j <= S_j * alpha^(FCR+j) XOR In_Sym on every accepted symbol (In_Valid=1); GF multiply modulo PRIM_POLY.
REQ-005 On the first symbol of a codeword, load S_j <= In_Sym (no feedback term), so frames run back-to-back with no bubble.
REQ-006 Symbol counter 0..N-1, width ceil(log2 N); advances only on accepted symbols; wraps to 0 after N-1.
REQ-007 States: IDLE (wait for In_Valid&In_Sof), ACC (counting). IDLE ignores In_Valid without In_Sof. ACC->IDLE after symbol N-1 unless that cycle... n/a; symbol N-1 is always last. In IDLE or ACC at count 0, In_Valid&In_Sof starts a frame; when ACC count reaches N-1 next state is IDLE, next In_Sof accepted the following cycle.
REQ-008 In_Valid=0 stalls: accumulators and counter hold, no output change.
REQ-009 On acceptance of symbol N-1 the final syndromes (including that symbol) are registered into Out_S, Out_NoErr set, and Out_Valid=1 on the next cycle; latency = 1 cycle after last symbol.
REQ-010 Out_S and Out_NoErr hold until the next completed codeword; Out_Valid high exactly one cycle per codeword.
REQ-011 In_Valid&In_Sof while ACC with count !=0: discard partial frame, restart at count 1 with this symbol loaded per REQ-005, pulse Sync_Err next cycle; no Out_Valid for the discarded frame.
REQ-012 In_Sof on the symbol immediately after symbol N-1 is normal (no Sync_Err).
REQ-013 All output paths registered; no combinational path input->output.

Reset
REQ-014 Reset=1: state IDLE, counter 0, accumulators 0, Out_S 0, Out_NoErr 0, Out_Valid 0, Sync_Err 0.
REQ-015 Reset mid-codeword discards the partial frame; no Out_Valid produced for it; inputs during Reset ignored.

Structure
REQ-016 Shared package rs_pkg holds M, N, PRIM_POLY defaults and a constant function computing alpha^k for elaboration-time multiplier constants.
REQ-017 One sub-module rs_gf_const_mul (M-bit input times constant alpha^k, parameter K, pure XOR network), instantiated NSYM times via generate.

Verification
REQ-018 Reset, then 204 zero symbols with In_Sof on first -> Out_Valid one cycle after last symbol, Out_S all 0, Out_NoErr=1.
REQ-019 203 zeros then last symbol 8'h5A -> every S_j = 8'h5A, Out_NoErr=0.
REQ-020 Valid DVB-T codeword from reference encoder model with In_Valid toggling 1/0 randomly -> Out_S all 0, Out_Valid exactly once, timing relative to last accepted symbol unchanged.
REQ-021 Two codewords back-to-back, second has symbol 0 = 8'h01 -> first Out_Valid NoErr=1; second S_1 = 8'h01, S_j matches software model alpha^(203*(j-1)).
REQ-022 In_Sof asserted at count 100 of a frame, then 204 zeros -> Sync_Err one pulse, single Out_Valid with Out_NoErr=1.
REQ-023 Reset asserted at count 50, then full zero codeword -> only one Out_Valid, Out_S all 0.
